fifo_wr_arb: RTL

Round-robin write-port arbiter that shares the write side of the asynchronous FIFO between `NUM_REQ` requesters in the write clock domain. It grants one requester at a time for a bounded burst and drives the FIFO write-increment and write data. It also honours the FIFO `full` flag and returns a per-word acknowledge to the granted requester. It sits between the write-domain producers and the FIFO write-pointer logic.

---
 rtl/fifo_wr_arb_pkg.sv | 20 ++
 rtl/fifo_wr_arb_rr_pick.sv | 38 +++
 rtl/fifo_wr_arb.sv | 119 +++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and parameter bounds for the FIFO write-port arbiter.
// Also provides an index-width helper that never returns zero.
package fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int NUM_REQ_MIN   = 2;
    localparam int NUM_REQ_MAX   = 8;
    localparam int MAX_BURST_MIN = 1;
    localparam int MAX_BURST_MAX = 16;

    // $clog2 of 1 or 2 would give a zero- or one-bit field; keep at least one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requesting index after
// last_owner, scanning upward and wrapping to 0.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W:0]     cand [NUM_REQ];
    logic [NUM_REQ-1:0] hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [IDX_W:0] sum;
            // Slot gi holds the candidate at distance gi+1 from the last owner.
            assign sum       = {1'b0, last_owner} + (IDX_W+1)'(gi + 1);
            assign cand[gi]  = (sum >= (IDX_W+1)'(NUM_REQ)) ? sum - (IDX_W+1)'(NUM_REQ) : sum;
            assign hit[gi]   = req[cand[gi][IDX_W-1:0]];
        end
    endgenerate

    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                found = 1'b1;
                index = cand[k][IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter sharing the async FIFO write port between NUM_REQ
// producers; grants bounded bursts and stalls on the FIFO full flag.
module fifo_wr_arb
    import fifo_wr_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic                          winc,
    output logic [DATA_WIDTH-1:0]         wdata,
    output logic [NUM_REQ-1:0]            ack,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IDX_W = clog2_min1(NUM_REQ);
    localparam int CNT_W = clog2_min1(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;
    logic                owner_req;
    logic                wr_fire;
    logic [DATA_WIDTH-1:0] data_slice [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_owner_q),
        .found      (pick_found),
        .index      (pick_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
            assign data_slice[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
            assign ack[gi]        = winc & (owner_q == IDX_W'(gi));
        end
    endgenerate

    assign owner_req = req[owner_q];
    assign wr_fire   = (state_q == ST_BURST) & owner_req & ~full;
    // Suppress the write in a reset cycle so an interrupted burst adds nothing.
    assign winc      = wr_fire & ~RST;
    assign wdata     = data_slice[owner_q];
    assign grant     = grant_q;
    assign busy      = (state_q == ST_BURST);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d      = ST_BURST;
                    owner_d      = pick_idx;
                    last_owner_d = pick_idx;
                    grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            ST_BURST: begin
                if (!owner_req) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    beat_cnt_d = '0;
                end else if (wr_fire) begin
                    if (beat_cnt_q == LAST_BEAT) begin
                        state_d    = ST_IDLE;
                        grant_d    = '0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_IDX;
            grant_q      <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule
